dmem_sram_responder: RTL and testbench

- Data-side memory responder answering the MEM stage's SRAM-like data requests: byte enables, size, address, write data, and a read-enable/write flag.
- Word-organised synchronous memory array behind an addr_ok/data_ok handshake with a programmable response latency.
- Sits between the CPU data port and the bus/cache bypass. Serves as the on-chip scratch data memory and as the bench stand-in for the data bus.

---
 rtl/dmem_sram_responder_if.sv | 24 ++
 rtl/dmem_sram_responder.sv | 129 ++++++++++++
 tb/tb_dmem_sram_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_sram_responder_if.sv
// Request/response bus between the CPU data port (master) and the data
// memory responder (slave): SRAM-like request with an addr_ok/data_ok handshake.
interface dmem_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req, wr, size, sel, addr, wdata,
    input  addr_ok, data_ok, rdata, busy
  );

  modport slave (
    input  req, wr, size, sel, addr, wdata,
    output addr_ok, data_ok, rdata, busy
  );
endinterface

// File: rtl/dmem_sram_responder.sv
// Word-organised scratch data memory with a fixed-latency addr_ok/data_ok handshake.
// Optional DSRAM_STALL_INJECT_EN: LFSR-driven pseudo-random acceptance stalls.
//
//   state | meaning
//   IDLE  | ready, addr_ok asserted (unless a stall is injected)
//   WAIT  | request latched, latency counter running down
//   RESP  | data_ok for one cycle; a latched write commits at the end of it
module dmem_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_sram_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_idx;
  logic                addr_ok;
  logic                data_ok;
  logic                stall;
  logic                unused_bits;

  logic [31:0] mem [2**ADDR_W];

`ifdef DSRAM_STALL_INJECT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        addr_ok = ~stall;
        if (bus.req && !stall) begin
          wr_d    = bus.wr;
          sel_d   = bus.sel;
          idx_d   = bus.addr[ADDR_W+1:2];
          wdata_d = bus.wdata;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Single-cycle latency reads the array with the index being latched now.
            state_d = RESP;
            rd_en   = ~bus.wr;
            rd_idx  = bus.addr[ADDR_W+1:2];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rd_en   = ~wr_q;
        end
      end
      RESP: begin
        data_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (rd_en) rdata_q <= mem[rd_idx];
    end
  end

  // Array is not reset; an async reset forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != IDLE);

  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench for dmem_sram_responder at LATENCY 1, 2 and 3 with hand-computed
// expected values.
module tb_dmem_sram_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // index 0: LATENCY=1, index 1: LATENCY=2, index 2: LATENCY=3
  logic        req_v   [3];
  logic        wr_v    [3];
  logic [1:0]  size_v  [3];
  logic [3:0]  sel_v   [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        addr_ok_w [3];
  logic        data_ok_w [3];
  logic [31:0] rdata_w   [3];
  logic        busy_w    [3];

  dmem_sram_responder_if b1 ();
  dmem_sram_responder_if b2 ();
  dmem_sram_responder_if b3 ();

  assign b1.req = req_v[0];  assign b1.wr = wr_v[0];  assign b1.size = size_v[0];
  assign b1.sel = sel_v[0];  assign b1.addr = addr_v[0];  assign b1.wdata = wdata_v[0];
  assign b2.req = req_v[1];  assign b2.wr = wr_v[1];  assign b2.size = size_v[1];
  assign b2.sel = sel_v[1];  assign b2.addr = addr_v[1];  assign b2.wdata = wdata_v[1];
  assign b3.req = req_v[2];  assign b3.wr = wr_v[2];  assign b3.size = size_v[2];
  assign b3.sel = sel_v[2];  assign b3.addr = addr_v[2];  assign b3.wdata = wdata_v[2];

  assign addr_ok_w[0] = b1.addr_ok;  assign data_ok_w[0] = b1.data_ok;
  assign rdata_w[0]   = b1.rdata;    assign busy_w[0]    = b1.busy;
  assign addr_ok_w[1] = b2.addr_ok;  assign data_ok_w[1] = b2.data_ok;
  assign rdata_w[1]   = b2.rdata;    assign busy_w[1]    = b2.busy;
  assign addr_ok_w[2] = b3.addr_ok;  assign data_ok_w[2] = b3.data_ok;
  assign rdata_w[2]   = b3.rdata;    assign busy_w[2]    = b3.busy;

  dmem_sram_responder #(.ADDR_W(10), .LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_sram_responder #(.ADDR_W(10), .LATENCY(2)) dut_l2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_sram_responder #(.ADDR_W(10), .LATENCY(3)) dut_l3 (.clk(clk), .rst(rst), .bus(b3));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; inputs are scrambled right after acceptance so any
  // use of live inputs while busy shows up as a wrong result.
  task automatic xact(input int d, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int lat, input string tag, output logic [31:0] rd);
    int k;
    bit got;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy_w[d]), 32'd0);
    req_v[d] = 1'b1; wr_v[d] = w; sel_v[d] = s; addr_v[d] = a; wdata_v[d] = wd;
    size_v[d] = 2'd2;
    @(posedge clk);
    #1;
    req_v[d] = 1'b0; wr_v[d] = ~w; sel_v[d] = ~s; addr_v[d] = ~a; wdata_v[d] = ~wd;
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (data_ok_w[d]) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_busy_resp"}, 32'(busy_w[d]), 32'd1);
    rd = rdata_w[d];
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(data_ok_w[d]), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy_w[d]), 32'd0);
  endtask

  logic [31:0] rd;
  int acc [8];
  int dok [8];
  int na, nd, viol, dok_after;
  bit prev_dok;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; wr_v[i] = 1'b0; size_v[i] = 2'd0;
      sel_v[i] = 4'h0; addr_v[i] = 32'h0; wdata_v[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_addr_ok", 32'(addr_ok_w[1]), 32'd1);
    chk("rst_data_ok", 32'(data_ok_w[1]), 32'd0);
    chk("rst_rdata",   rdata_w[1],        32'h0);
    chk("rst_busy",    32'(busy_w[1]),    32'd0);

    // word write then read
    xact(1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 2, "w100", rd);
    xact(1, 1'b0, 4'hF, 32'h100, 32'h0, 2, "r100", rd);
    chk("r100_data", rd, 32'hDEADBEEF);

    // byte-lane merge
    xact(1, 1'b1, 4'hF, 32'h8, 32'h11223344, 2, "w8", rd);
    xact(1, 1'b1, 4'b0010, 32'h9, 32'h0000AB00, 2, "w9", rd);
    xact(1, 1'b0, 4'b0001, 32'h8, 32'h0, 2, "r8", rd);
    chk("r8_merge", rd, 32'h1122AB44);

    // sel=0 completes without writing
    xact(1, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF, 2, "w8_sel0", rd);
    xact(1, 1'b0, 4'hF, 32'h8, 32'h0, 2, "r8_sel0", rd);
    chk("r8_sel0_data", rd, 32'h1122AB44);

    // wrap-around; write response leaves rdata untouched
    xact(1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 2, "w1000", rd);
    chk("w1000_rdata_hold", rd, 32'h1122AB44);
    xact(1, 1'b0, 4'hF, 32'h0, 32'h0, 2, "r0", rd);
    chk("r0_wrap", rd, 32'hCAFEF00D);
    xact(1, 1'b0, 4'h1, 32'h3, 32'h0, 2, "r3", rd);
    chk("r3_lowbits", rd, 32'hCAFEF00D);

    // LATENCY=1 boundary
    xact(0, 1'b1, 4'hF, 32'h40, 32'h0BADCAFE, 1, "l1_w40", rd);
    xact(0, 1'b0, 4'hF, 32'h40, 32'h0, 1, "l1_r40", rd);
    chk("l1_r40_data", rd, 32'h0BADCAFE);

    // LATENCY=3, req held high continuously
    na = 0; nd = 0; viol = 0; prev_dok = 1'b0;
    for (int i = 0; i < 8; i++) begin acc[i] = -100; dok[i] = -100; end
    @(negedge clk);
    req_v[2] = 1'b1; wr_v[2] = 1'b1; sel_v[2] = 4'hF; addr_v[2] = 32'h40; wdata_v[2] = 32'h0;
    for (int n = 0; n < 16; n++) begin
      if (addr_ok_w[2]) begin if (na < 8) acc[na] = n; na++; end
      if (data_ok_w[2]) begin if (nd < 8) dok[nd] = n; nd++; end
      if (addr_ok_w[2] == busy_w[2]) viol++;
      if (data_ok_w[2] && prev_dok) viol++;
      prev_dok = data_ok_w[2];
      @(negedge clk);
    end
    req_v[2] = 1'b0;
    chk("l3_accepts", 32'(na), 32'd4);
    chk("l3_resps",   32'(nd), 32'd4);
    for (int i = 0; i < 3; i++) chk("l3_spacing", 32'(acc[i+1] - acc[i]), 32'd4);
    for (int i = 0; i < 4; i++) chk("l3_resp_lat", 32'(dok[i] - acc[i]), 32'd3);
    chk("l3_handshake_viol", 32'(viol), 32'd0);
    repeat (4) @(negedge clk);

    // reset in WAIT drops a pending write
    xact(1, 1'b1, 4'hF, 32'h20, 32'h0, 2, "w20_init", rd);
    xact(1, 1'b0, 4'hF, 32'h8, 32'h0, 2, "r8_pre_rst", rd);
    chk("r8_pre_rst_data", rd, 32'h1122AB44);
    @(negedge clk);
    req_v[1] = 1'b1; wr_v[1] = 1'b1; sel_v[1] = 4'hF; addr_v[1] = 32'h20;
    wdata_v[1] = 32'h55AA55AA;
    @(posedge clk);
    #1;
    req_v[1] = 1'b0;
    @(negedge clk);
    chk("pend_busy", 32'(busy_w[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk("inrst_addr_ok", 32'(addr_ok_w[1]), 32'd1);
    chk("inrst_busy",    32'(busy_w[1]),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_addr_ok", 32'(addr_ok_w[1]), 32'd1);
    chk("postrst_rdata",   rdata_w[1],        32'h0);
    dok_after = 0;
    for (int n = 0; n < 5; n++) begin
      if (data_ok_w[1]) dok_after++;
      @(negedge clk);
    end
    chk("postrst_no_data_ok", 32'(dok_after), 32'd0);
    xact(1, 1'b0, 4'hF, 32'h20, 32'h0, 2, "r20", rd);
    chk("r20_not_committed", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
